// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer write scheduler.
package fb_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int CW        = 11;
  localparam int OOB_W     = 16;

  typedef logic [CW-1:0] coord_t;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fb_sched_state_e;

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Requester, clear-control and framebuffer write-port signals of the scheduler.
interface fb_write_scheduler_if #(
  parameter int OOB_W = fb_pkg::OOB_W
);
  import fb_pkg::*;

  logic             req0_valid;
  coord_t           req0_x;
  coord_t           req0_y;
  logic             req0_color;
  logic             req0_ready;

  logic             req1_valid;
  coord_t           req1_x;
  coord_t           req1_y;
  logic             req1_color;
  logic             req1_ready;

  logic             clear_start;
  logic             clear_color;
  logic             clear_busy;
  logic             clear_done;

  coord_t           fb_x;
  coord_t           fb_y;
  logic             fb_color;
  logic             fb_write;
  logic [OOB_W-1:0] oob_count;

  modport master (
    output req0_valid, req0_x, req0_y, req0_color,
    output req1_valid, req1_x, req1_y, req1_color,
    output clear_start, clear_color,
    input  req0_ready, req1_ready, clear_busy, clear_done,
    input  fb_x, fb_y, fb_color, fb_write, oob_count
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_color,
    input  req1_valid, req1_x, req1_y, req1_color,
    input  clear_start, clear_color,
    output req0_ready, req1_ready, clear_busy, clear_done,
    output fb_x, fb_y, fb_color, fb_write, oob_count
  );

endinterface

// File: rtl/fb_clear_scan.sv
// Raster x/y counter for the full-screen clear. The counters hold the pixel
// currently on the framebuffer port; nxt_x/nxt_y is the pixel to issue next.
module fb_clear_scan
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT
) (
  input  logic   clk50,
  input  logic   reset,
  input  logic   start,
  input  logic   step,
  output coord_t nxt_x,
  output coord_t nxt_y,
  output logic   last,
  output logic   done
);

  localparam coord_t X_MAX = coord_t'(FB_WIDTH - 1);
  localparam coord_t Y_MAX = coord_t'(FB_HEIGHT - 1);

  coord_t x;
  coord_t y;
  logic   x_wrap;

  assign x_wrap = (x == X_MAX);
  assign last   = x_wrap && (y == Y_MAX);

  // Next raster position; stepping past the last pixel folds back to the origin.
  always_comb begin
    nxt_x = x_wrap ? '0 : x + 1'b1;
    nxt_y = y;
    if (last) begin
      nxt_y = '0;
    end else if (x_wrap) begin
      nxt_y = y + 1'b1;
    end
  end

  // Counter register plus the one-cycle done pulse after the last pixel.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      done <= 1'b0;
    end else begin
      done <= step && last;
      if (start) begin
        x <= '0;
        y <= '0;
      end else if (step) begin
        x <= nxt_x;
        y <= nxt_y;
      end
    end
  end

endmodule

// File: rtl/fb_write_scheduler.sv
// Owns the framebuffer write port: round-robin between two pixel requesters,
// drops out-of-range beats, and runs a full-screen clear when asked.
//
//   state | meaning
//   ARB   | serve requesters; clear_start launches a clear
//   CLEAR | one clear pixel on the port every cycle, requesters held off
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
  parameter int OOB_W     = fb_pkg::OOB_W
) (
  input logic                 clk50,
  input logic                 reset,
  fb_write_scheduler_if.slave bus
);

  fb_sched_state_e  state;
  fb_sched_state_e  state_nxt;
  logic             rr_fav1;
  logic             grant0, grant1;
  logic             ready0, ready1;
  logic             xfer0, xfer1, xfer;
  coord_t           sel_x, sel_y;
  logic             sel_color;
  logic             in_range;
  logic             scan_start, scan_step, scan_last, scan_done;
  coord_t           scan_nxt_x, scan_nxt_y;
  logic             clr_color_q;
  coord_t           fb_x_q, fb_y_q;
  logic             fb_color_q, fb_write_q;
  logic [OOB_W-1:0] oob_q;

  // rr_fav1 names the requester that wins a tie: the one not granted last.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || !rr_fav1);
  assign grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_fav1);

  assign xfer0     = ready0 && bus.req0_valid;
  assign xfer1     = ready1 && bus.req1_valid;
  assign xfer      = xfer0 || xfer1;
  assign sel_x     = xfer1 ? bus.req1_x     : bus.req0_x;
  assign sel_y     = xfer1 ? bus.req1_y     : bus.req0_y;
  assign sel_color = xfer1 ? bus.req1_color : bus.req0_color;
  assign in_range  = (sel_x < coord_t'(FB_WIDTH)) && (sel_y < coord_t'(FB_HEIGHT));

  fb_clear_scan #(
    .FB_WIDTH (FB_WIDTH),
    .FB_HEIGHT(FB_HEIGHT)
  ) u_scan (
    .clk50(clk50),
    .reset(reset),
    .start(scan_start),
    .step (scan_step),
    .nxt_x(scan_nxt_x),
    .nxt_y(scan_nxt_y),
    .last (scan_last),
    .done (scan_done)
  );

  // State register.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  // Next state and grants; a clear request outranks both requesters.
  always_comb begin
    state_nxt  = state;
    ready0     = 1'b0;
    ready1     = 1'b0;
    scan_start = 1'b0;
    scan_step  = 1'b0;
    case (state)
      ARB: begin
        if (bus.clear_start) begin
          state_nxt  = CLEAR;
          scan_start = 1'b1;
        end else begin
          ready0 = grant0;
          ready1 = grant1;
        end
      end
      CLEAR: begin
        scan_step = 1'b1;
        if (scan_last) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  // Round-robin pointer moves only when a beat actually transfers.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)      rr_fav1 <= 1'b0;
    else if (xfer0) rr_fav1 <= 1'b1;
    else if (xfer1) rr_fav1 <= 1'b0;
  end

  // Framebuffer port register: pixel 0 of a clear loads with the start, so the
  // port is busy exactly while the FSM sits in CLEAR.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      fb_x_q      <= '0;
      fb_y_q      <= '0;
      fb_color_q  <= 1'b0;
      fb_write_q  <= 1'b0;
      clr_color_q <= 1'b0;
    end else begin
      fb_write_q <= 1'b0;
      if (scan_start) begin
        fb_x_q      <= '0;
        fb_y_q      <= '0;
        fb_color_q  <= bus.clear_color;
        fb_write_q  <= 1'b1;
        clr_color_q <= bus.clear_color;
      end else if (scan_step && !scan_last) begin
        fb_x_q     <= scan_nxt_x;
        fb_y_q     <= scan_nxt_y;
        fb_color_q <= clr_color_q;
        fb_write_q <= 1'b1;
      end else if (xfer && in_range) begin
        fb_x_q     <= sel_x;
        fb_y_q     <= sel_y;
        fb_color_q <= sel_color;
        fb_write_q <= 1'b1;
      end
    end
  end

  // Saturating count of accepted-but-dropped out-of-range beats.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)                                   oob_q <= '0;
    else if (xfer && !in_range && (oob_q != '1)) oob_q <= oob_q + 1'b1;
  end

  // Readies are forced low while reset is held so every output reads 0.
  assign bus.req0_ready = ready0 && !reset;
  assign bus.req1_ready = ready1 && !reset;
  assign bus.clear_busy = (state == CLEAR);
  assign bus.clear_done = scan_done;
  assign bus.fb_x       = fb_x_q;
  assign bus.fb_y       = fb_y_q;
  assign bus.fb_color   = fb_color_q;
  assign bus.fb_write   = fb_write_q;
  assign bus.oob_count  = oob_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler on a reduced 32x24 screen with an 8-bit drop counter.
module tb_fb_write_scheduler;
  import fb_pkg::*;

  localparam int W       = 32;
  localparam int H       = 24;
  localparam int NPIX    = W * H;
  localparam int OW      = 8;
  localparam int OOB_MAX = (1 << OW) - 1;

  logic clk50 = 1'b0;
  logic reset;
  always #5 clk50 = ~clk50;

  fb_write_scheduler_if #(.OOB_W(OW)) bus();

  fb_write_scheduler #(
    .FB_WIDTH (W),
    .FB_HEIGHT(H),
    .OOB_W    (OW)
  ) dut (
    .clk50(clk50),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: clear progress as a linear pixel index, plus last-granted id.
  bit m_busy, m_done, m_last1, m_ccol, m_c, m_w;
  int m_pix, m_x, m_y, m_oob;
  int wr_count;
  logic last_r0, last_r1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_last1 = 1; m_ccol = 0; m_c = 0; m_w = 0;
    m_pix = 0; m_x = 0; m_y = 0; m_oob = 0;
  endtask

  task automatic set_idle();
    bus.req0_valid = 0; bus.req0_x = '0; bus.req0_y = '0; bus.req0_color = 0;
    bus.req1_valid = 0; bus.req1_x = '0; bus.req1_y = '0; bus.req1_color = 0;
    bus.clear_start = 0; bus.clear_color = 0;
  endtask

  task automatic drive0(input logic v, input int x, input int y, input logic c);
    bus.req0_valid = v; bus.req0_x = coord_t'(x); bus.req0_y = coord_t'(y); bus.req0_color = c;
  endtask

  task automatic drive1(input logic v, input int x, input int y, input logic c);
    bus.req1_valid = v; bus.req1_x = coord_t'(x); bus.req1_y = coord_t'(y); bus.req1_color = c;
  endtask

  task automatic check_outputs();
    chk("fb_write",   bus.fb_write,   m_w);
    chk("fb_x",       bus.fb_x,       m_x);
    chk("fb_y",       bus.fb_y,       m_y);
    chk("fb_color",   bus.fb_color,   m_c);
    chk("clear_busy", bus.clear_busy, m_busy);
    chk("clear_done", bus.clear_done, m_done);
    chk("oob_count",  bus.oob_count,  m_oob);
  endtask

  // Entered 1 time unit after a rising edge with inputs already applied.
  task automatic run_cycle();
    bit e0, e1, cs, bc;
    int bx, by;
    #1;
    cs = bus.clear_start;
    e0 = !m_busy && !cs && bus.req0_valid && (!bus.req1_valid || m_last1);
    e1 = !m_busy && !cs && bus.req1_valid && (!bus.req0_valid || !m_last1);
    last_r0 = bus.req0_ready;
    last_r1 = bus.req1_ready;
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    m_w = 0;
    m_done = 0;
    if (!m_busy && cs) begin
      m_busy = 1; m_pix = 0; m_ccol = bus.clear_color;
      m_w = 1; m_x = 0; m_y = 0; m_c = m_ccol;
    end else if (m_busy) begin
      if (m_pix == NPIX - 1) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_pix++;
        m_w = 1; m_x = m_pix % W; m_y = m_pix / W; m_c = m_ccol;
      end
    end else if (e0 || e1) begin
      bx = e1 ? int'(bus.req1_x) : int'(bus.req0_x);
      by = e1 ? int'(bus.req1_y) : int'(bus.req0_y);
      bc = e1 ? bus.req1_color : bus.req0_color;
      m_last1 = e1;
      if (bx < W && by < H) begin
        m_w = 1; m_x = bx; m_y = by; m_c = bc;
      end else if (m_oob < OOB_MAX) begin
        m_oob++;
      end
    end
    @(posedge clk50);
    #1;
    if (bus.fb_write === 1'b1) wr_count++;
    check_outputs();
  endtask

  function automatic coord_t rnd_coord(input int lim);
    case ($urandom_range(0, 9))
      0:       return coord_t'($urandom_range(640, 2047));
      1:       return coord_t'(lim);
      default: return coord_t'($urandom_range(0, lim - 1));
    endcase
  endfunction

  // Run a clear to completion; optionally re-request mid-way and stop at the done pulse.
  task automatic run_clear(input logic color, input string tag, input int restart_at);
    bit seen;
    seen = 0;
    bus.clear_start = 1; bus.clear_color = color;
    wr_count = 0;
    run_cycle();
    bus.clear_start = 0;
    for (int k = 1; k <= NPIX + 4 && !seen; k++) begin
      if (k == 1) begin
        chk({tag, "_first_x"}, bus.fb_x, 0);
        chk({tag, "_first_y"}, bus.fb_y, 0);
      end
      if (k == W) begin
        chk({tag, "_wrap_from_x"}, bus.fb_x, W - 1);
        chk({tag, "_wrap_from_y"}, bus.fb_y, 0);
      end
      if (k == W + 1) begin
        chk({tag, "_wrap_to_x"}, bus.fb_x, 0);
        chk({tag, "_wrap_to_y"}, bus.fb_y, 1);
      end
      if (k == NPIX) begin
        chk({tag, "_last_x"}, bus.fb_x, W - 1);
        chk({tag, "_last_y"}, bus.fb_y, H - 1);
      end
      if (bus.clear_done === 1'b1) begin
        seen = 1;
        chk({tag, "_writes"}, wr_count, NPIX);
      end else begin
        bus.clear_start = (k == restart_at);
        bus.clear_color = ~color;
        run_cycle();
        bus.clear_start = 0;
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    set_idle();
    model_reset();
    bus.req0_valid = 1;
    #2;
    chk("rst_req0_ready", bus.req0_ready, 0);
    check_outputs();
    bus.req0_valid = 0;
    repeat (2) @(posedge clk50);
    #3 reset = 0;
    @(posedge clk50);
    #1;
    check_outputs();

    // Single req0 beat, then an idle cycle.
    drive0(1, 10, 20, 1);
    run_cycle();
    chk("t1_ready", last_r0, 1);
    chk("t1_write", bus.fb_write, 1);
    chk("t1_x", bus.fb_x, 10);
    chk("t1_y", bus.fb_y, 20);
    set_idle();
    run_cycle();
    chk("t1_write_off", bus.fb_write, 0);
    chk("t1_x_hold", bus.fb_x, 10);

    // Out-of-range req1 beat: handshaken, dropped, counted.
    drive1(1, 640, 5, 1);
    run_cycle();
    chk("t4_ready", last_r1, 1);
    chk("t4_write", bus.fb_write, 0);
    chk("t4_oob", bus.oob_count, 1);
    set_idle();

    // Dual traffic alternates starting with req0.
    drive0(1, 1, 1, 1);
    drive1(1, 2, 2, 0);
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      chk("t2_grant_is_req1", last_r1, (i % 2));
      chk("t2_write", bus.fb_write, 1);
      if (last_r0 === 1'b1) drive0(1, 3 + i, 1, 1);
      if (last_r1 === 1'b1) drive1(1, 4 + i, 2, 0);
    end
    set_idle();

    // Range boundaries.
    drive0(1, W - 1, H - 1, 1); run_cycle();
    chk("bnd_in_write", bus.fb_write, 1);
    drive0(1, W, 0, 1);         run_cycle();
    drive0(1, 0, H, 1);         run_cycle();
    chk("bnd_oob", bus.oob_count, 3);
    set_idle();

    // Clear to 0 with req1 waiting and a restart attempt mid-way.
    drive1(1, 7, 8, 1);
    run_clear(1'b0, "t3", 100);
    run_cycle();
    chk("t3_req1_served", last_r1, 1);
    set_idle();
    run_cycle();

    // Clear requested in the same cycle as a req0 beat.
    drive0(1, 5, 6, 0);
    run_clear(1'b1, "t6", 300);
    run_cycle();
    chk("t6_req0_served", last_r0, 1);
    chk("t6_req0_written", bus.fb_x, 5);
    set_idle();

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      if (bus.req0_valid !== 1'b1 || last_r0 === 1'b1)
        drive0($urandom_range(0, 1), rnd_coord(W), rnd_coord(H), $urandom_range(0, 1));
      if (bus.req1_valid !== 1'b1 || last_r1 === 1'b1)
        drive1($urandom_range(0, 1), rnd_coord(W), rnd_coord(H), $urandom_range(0, 1));
      bus.clear_start = ($urandom_range(0, 599) == 0);
      bus.clear_color = $urandom_range(0, 1);
      run_cycle();
    end
    set_idle();
    for (int i = 0; i < NPIX + 4 && bus.clear_busy === 1'b1; i++) run_cycle();

    // Saturate the drop counter.
    drive0(1, W, 0, 1);
    for (int i = 0; i < OOB_MAX + 4; i++) run_cycle();
    chk("sat_oob", bus.oob_count, OOB_MAX);
    set_idle();
    run_cycle();

    // Reset in the middle of a clear.
    bus.clear_start = 1; bus.clear_color = 1;
    run_cycle();
    bus.clear_start = 0;
    for (int i = 0; i < 50; i++) run_cycle();
    bus.req0_valid = 1;
    reset = 1;
    #1;
    chk("t5_req0_ready", bus.req0_ready, 0);
    chk("t5_busy", bus.clear_busy, 0);
    chk("t5_write", bus.fb_write, 0);
    chk("t5_x", bus.fb_x, 0);
    chk("t5_oob", bus.oob_count, 0);
    set_idle();
    repeat (2) @(posedge clk50);
    #3 reset = 0;
    model_reset();
    @(posedge clk50);
    #1;
    check_outputs();
    drive0(1, 9, 11, 1);
    run_cycle();
    chk("t5_beat_write", bus.fb_write, 1);
    chk("t5_beat_x", bus.fb_x, 9);
    set_idle();
    for (int i = 0; i < 8; i++) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
